// File: rtl/y86_instr_encoder.sv
// Purpose : serializes one Y86-64 instruction tuple into its little-endian byte image on a byte write port.
// Latency : first byte one cycle after accept; an L-byte instruction needs L+1 cycles including the return to IDLE.
// Backpressure: wr_ready_i low freezes wr_en_o/wr_addr_o/wr_data_o; in_ready_o stays low until the image is fully written.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   in_valid_i / in_ready_o  tuple handshake (icode_i, ifun_i, rA_i, rB_i, valC_i)
//   set_addr_i, addr_i       load the write address (IDLE only)
//   wr_en_o, wr_addr_o, wr_data_o, wr_ready_i   byte write port to instruction memory
//   err_o                    one-cycle pulse after a rejected tuple
//   busy_o                   high while bytes are being emitted
module y86_instr_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  icode_i,
  input  logic [3:0]  ifun_i,
  input  logic [3:0]  rA_i,
  input  logic [3:0]  rB_i,
  input  logic [63:0] valC_i,
  input  logic        set_addr_i,
  input  logic [63:0] addr_i,
  output logic        wr_en_o,
  output logic [63:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic        wr_ready_i,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q;
  logic [79:0] shreg_q;   // byte 0 of the image sits in [7:0]; shifted right per transfer
  logic [3:0]  len_q;
  logic [3:0]  idx_q;
  logic        err_q;

  logic [3:0]  len_c;     // 0 marks an unknown icode
  logic [3:0]  max_fun_c;
  logic        legal_c;
  logic [3:0]  ra_eff, rb_eff;
  logic [7:0]  byte0_c, spec_c;
  logic [79:0] image_c;
  logic        accept, take, xfer, last_byte;

  // Instruction length and highest legal function code per icode.
  always_comb begin
    len_c     = 4'd0;
    max_fun_c = 4'd0;
    case (icode_i)
      4'h0, 4'h1, 4'h9:        len_c = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  len_c = 4'd2;
      4'h7, 4'h8:              len_c = 4'd9;
      4'h3, 4'h4, 4'h5:        len_c = 4'd10;
      default:                 len_c = 4'd0;
    endcase
    case (icode_i)
      4'h2, 4'h7: max_fun_c = 4'd6;
      4'h6:       max_fun_c = 4'd3;
      default:    max_fun_c = 4'd0;
    endcase
  end

  assign legal_c = (len_c != 4'd0) && (ifun_i <= max_fun_c);

  // irmovq has no source register; push/pop have no second register.
  assign ra_eff  = (icode_i == 4'h3) ? 4'hF : rA_i;
  assign rb_eff  = ((icode_i == 4'hA) || (icode_i == 4'hB)) ? 4'hF : rB_i;
  assign byte0_c = {icode_i, ifun_i};
  assign spec_c  = {ra_eff, rb_eff};

  always_comb begin
    image_c = '0;
    case (len_c)
      4'd1:    image_c = {72'd0, byte0_c};
      4'd2:    image_c = {64'd0, spec_c, byte0_c};
      4'd9:    image_c = {8'd0, valC_i, byte0_c};
      default: image_c = {valC_i, spec_c, byte0_c};
    endcase
  end

  assign in_ready_o = (state_q == IDLE) && !set_addr_i;
  assign accept     = in_valid_i && in_ready_o;
  assign take       = accept && legal_c;
  assign xfer       = (state_q == EMIT) && wr_ready_i;
  assign last_byte  = (idx_q == (len_q - 4'd1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = EMIT;
      EMIT:    if (xfer && last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= BASE_ADDR;
      shreg_q <= '0;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !legal_c;
      if (state_q == IDLE) begin
        // set_addr_i forces in_ready_o low, so a load and an accept never coincide.
        if (set_addr_i) addr_q <= addr_i;
        if (take) begin
          shreg_q <= image_c;
          len_q   <= len_c;
          idx_q   <= 4'd0;
        end
      end else if (xfer) begin
        shreg_q <= {8'h00, shreg_q[79:8]};
        idx_q   <= idx_q + 4'd1;
        addr_q  <= addr_q + 64'd1;   // wraps modulo 2^64
      end
    end
  end

  assign wr_en_o   = (state_q == EMIT);
  assign wr_addr_o = addr_q;
  assign wr_data_o = (state_q == EMIT) ? shreg_q[7:0] : 8'h00;
  assign busy_o    = (state_q == EMIT);
  assign err_o     = err_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_ready_o;
  logic [3:0]  icode_i, ifun_i, rA_i, rB_i;
  logic [63:0] valC_i;
  logic        set_addr_i;
  logic [63:0] addr_i;
  logic        wr_en_o;
  logic [63:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        wr_ready_i;
  logic        err_o, busy_o;

  y86_instr_encoder #(.BASE_ADDR(64'd0)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .icode_i(icode_i), .ifun_i(ifun_i), .rA_i(rA_i), .rB_i(rB_i), .valC_i(valC_i),
    .set_addr_i(set_addr_i), .addr_i(addr_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side observer: every accepted byte write, sampled mid-cycle.
  typedef struct {
    logic [63:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;
  wr_t cap[$];
  int  err_cnt = 0;
  always @(negedge clk) begin
    if (wr_en_o && wr_ready_i) cap.push_back('{wr_addr_o, wr_data_o, cyc});
    if (err_o) err_cnt++;
  end

  logic [63:0] exp_addr;
  logic [7:0]  exp_q[$];
  logic        exp_ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: byte image straight from the ISA encoding rules.
  task automatic ref_encode(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
    int len, maxf;
    logic [3:0] r1, r2;
    exp_q.delete();
    case (ic)
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h7, 4'h8:             len = 9;
      4'h3, 4'h4, 4'h5:       len = 10;
      default:                len = 0;
    endcase
    maxf   = (ic == 4'h2 || ic == 4'h7) ? 6 : (ic == 4'h6) ? 3 : 0;
    exp_ok = (len != 0) && (int'(fn) <= maxf);
    if (exp_ok) begin
      r1 = (ic == 4'h3) ? 4'hF : ra;
      r2 = (ic == 4'hA || ic == 4'hB) ? 4'hF : rb;
      exp_q.push_back({ic, fn});
      if (len == 2 || len == 10) exp_q.push_back({r1, r2});
      if (len >= 9) for (int k = 0; k < 8; k++) exp_q.push_back(vc[8*k +: 8]);
    end
  endtask

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic set_addr(input logic [63:0] a);
    set_addr_i = 1'b1;
    addr_i     = a;
    @(negedge clk);
    chk("set_addr_blocks_ready", in_ready_o, 0);
    @(posedge clk); #1;
    set_addr_i = 1'b0;
    exp_addr   = a;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, output int acc);
    int t;
    in_valid_i = 1'b1;
    icode_i = ic; ifun_i = fn; rA_i = ra; rB_i = rb; valC_i = vc;
    t = 0;
    @(negedge clk);
    while (!in_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("accept_timeout", 1, 0);
    @(posedge clk);
    acc = cyc;
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] vc, input bit rand_bp);
    int acc, t;
    ref_encode(ic, fn, ra, rb, vc);
    cap.delete();
    err_cnt = 0;
    send(ic, fn, ra, rb, vc, acc);
    if (!exp_ok) begin
      @(negedge clk);
      chk("err_pulse", err_o, 1);
      chk("err_no_busy", busy_o, 0);
      chk("err_ready_high", in_ready_o, 1);
      @(negedge clk);
      chk("err_one_cycle", err_o, 0);
      chk("err_no_write", cap.size(), 0);
      chk("err_count", err_cnt, 1);
      @(posedge clk); #1;
    end else begin
      t = 0;
      @(negedge clk);
      while (busy_o && t < 300) begin
        @(posedge clk); #1;
        wr_ready_i = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        t++;
      end
      if (t >= 300) chk("emit_timeout", 1, 0);
      chk("byte_count", cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
        chk("byte_data", cap[i].d, exp_q[i]);
        chk("byte_addr", cap[i].a, exp_addr + 64'(i));
        if (!rand_bp) chk("byte_cycle", cap[i].c, acc + 1 + i);
      end
      if (!rand_bp) begin
        chk("ready_again_cycle", cyc, acc + exp_q.size() + 1);
        chk("ready_again", in_ready_o, 1);
      end
      chk("no_err", err_cnt, 0);
      exp_addr = exp_addr + 64'(exp_q.size());
      @(posedge clk); #1;
      wr_ready_i = 1'b1;
    end
  endtask

  typedef struct packed {
    logic          do_set;
    logic [63:0]   set_val;
    logic [3:0]    ic, fn, ra, rb;
    logic [63:0]   vc;
    logic          exp_err;
    logic [3:0]    exp_len;
    logic [0:9][7:0] exp_b;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int acc;
    vecs[0]  = '{0, 64'h0,   4'h3, 4'h0, 4'h0, 4'h0, 64'h0123456789ABCDEF, 0, 10,
                 {8'h30, 8'hF0, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01}};
    vecs[1]  = '{0, 64'h0,   4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 0, 1, {8'h00, 72'h0}};
    vecs[2]  = '{0, 64'h0,   4'h6, 4'h0, 4'h3, 4'h1, 64'h0, 0, 2, {8'h60, 8'h31, 64'h0}};
    vecs[3]  = '{1, 64'h100, 4'h7, 4'h4, 4'h0, 4'h0, 64'h40, 0, 9, {8'h74, 8'h40, 64'h0}};
    vecs[4]  = '{0, 64'h0,   4'hA, 4'h0, 4'h0, 4'h3, 64'h0, 0, 2, {8'hA0, 8'h0F, 64'h0}};
    vecs[5]  = '{0, 64'h0,   4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 1, 0, 80'h0};
    vecs[6]  = '{0, 64'h0,   4'h6, 4'h5, 4'h1, 4'h2, 64'h0, 1, 0, 80'h0};
    vecs[7]  = '{0, 64'h0,   4'h2, 4'h1, 4'h1, 4'h2, 64'h0, 0, 2, {8'h21, 8'h12, 64'h0}};
    vecs[8]  = '{0, 64'h0,   4'hB, 4'h0, 4'h4, 4'h7, 64'h0, 0, 2, {8'hB0, 8'h4F, 64'h0}};
    vecs[9]  = '{0, 64'h0,   4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 0, 1, {8'h90, 72'h0}};
    vecs[10] = '{0, 64'h0,   4'h1, 4'h1, 4'h0, 4'h0, 64'h0, 1, 0, 80'h0};
    vecs[11] = '{0, 64'h0,   4'h5, 4'h0, 4'h7, 4'h5, 64'h10, 0, 10, {8'h50, 8'h75, 8'h10, 56'h0}};
    vecs[12] = '{0, 64'h0,   4'h4, 4'h0, 4'h1, 4'h2, 64'hFF, 0, 10, {8'h40, 8'h12, 8'hFF, 56'h0}};
    vecs[13] = '{1, 64'h2000, 4'h8, 4'h0, 4'h0, 4'h0, 64'h1234, 0, 9, {8'h80, 8'h34, 8'h12, 56'h0}};
    vecs[14] = '{0, 64'h0,   4'h7, 4'h6, 4'h0, 4'h0, 64'h0, 0, 9, {8'h76, 72'h0}};
    vecs[15] = '{0, 64'h0,   4'h7, 4'h7, 4'h0, 4'h0, 64'h0, 1, 0, 80'h0};

    rst_i = 1'b1; in_valid_i = 1'b0; icode_i = 0; ifun_i = 0; rA_i = 0; rB_i = 0;
    valC_i = 0; set_addr_i = 1'b0; addr_i = 0; wr_ready_i = 1'b1;
    #1;
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_wr_addr", wr_addr_o, 64'h0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", in_ready_o, 1);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    exp_addr = 64'h0;

    // Table vectors: the table's own expected image must agree with the observed writes.
    foreach (vecs[v]) begin
      if (vecs[v].do_set) set_addr(vecs[v].set_val);
      run_instr(vecs[v].ic, vecs[v].fn, vecs[v].ra, vecs[v].rb, vecs[v].vc, 1'b0);
      if (vecs[v].exp_err) begin
        chk("tbl_no_write", cap.size(), 0);
      end else begin
        chk("tbl_len", cap.size(), vecs[v].exp_len);
        for (int i = 0; i < int'(vecs[v].exp_len) && i < cap.size(); i++)
          chk("tbl_byte", cap[i].d, vecs[v].exp_b[i]);
      end
    end

    // Backpressure: stall three cycles while byte 2 of rrmovq is presented.
    begin
      logic [63:0] sa; logic [7:0] sd;
      ref_encode(4'h2, 4'h0, 4'h1, 4'h2, 64'h0);
      cap.delete();
      send(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, acc);
      @(posedge clk); #1 wr_ready_i = 1'b0;
      @(negedge clk);
      sa = wr_addr_o; sd = wr_data_o;
      chk("bp_data", sd, 8'h12);
      chk("bp_addr", sa, exp_addr + 64'd1);
      repeat (2) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_en_stable", wr_en_o, 1);
        chk("bp_addr_stable", wr_addr_o, sa);
        chk("bp_data_stable", wr_data_o, sd);
      end
      @(posedge clk); #1 wr_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_still_busy", busy_o, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_done", busy_o, 0);
      chk("bp_count", cap.size(), 2);
      for (int i = 0; i < 2 && i < cap.size(); i++) begin
        chk("bp_byte", cap[i].d, exp_q[i]);
        chk("bp_byte_addr", cap[i].a, exp_addr + 64'(i));
      end
      exp_addr = exp_addr + 64'd2;
      @(posedge clk); #1;
    end

    // Randomized tuples with random backpressure against the reference.
    for (int n = 0; n < 80; n++) begin
      logic [3:0] ic, fn;
      if ($urandom_range(0, 7) == 0) set_addr({$urandom, $urandom});
      ic = 4'($urandom_range(0, 15));
      fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      run_instr(ic, fn, 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b1);
    end

    // Address wrap, then reset in the middle of a second call.
    set_addr(64'hFFFF_FFFF_FFFF_FFFE);
    run_instr(4'h8, 4'h0, 4'h0, 4'h0, 64'h1000, 1'b0);
    if (cap.size() == 9) begin
      chk("wrap_ff", cap[1].a, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_zero", cap[2].a, 64'h0);
      chk("wrap_last", cap[8].a, 64'h6);
    end else begin
      chk("wrap_count", cap.size(), 9);
    end
    ref_encode(4'h8, 4'h0, 4'h0, 4'h0, 64'h0000_0000_AABB_CCDD);
    cap.delete();
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h0000_0000_AABB_CCDD, acc);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_data", wr_data_o, exp_q[3]);
    chk("pre_rst_addr", wr_addr_o, 64'h7 + 64'd3);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en_o, 0);
    chk("mid_rst_addr", wr_addr_o, 64'h0);
    chk("mid_rst_data", wr_data_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", in_ready_o, 1);
    chk("mid_rst_written", cap.size(), 3);
    @(posedge clk); #1 rst_i = 1'b0;
    exp_addr = 64'h0;
    run_instr(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
